// File: rtl/pipeline_ctrl.sv
// Central stall/flush/freeze sequencer for the 4-stage IF/ID/EX/WB pipeline.
// Optional stall counter output enabled by defining PIPELINE_CTRL_STALL_CNT_EN.
module pipeline_ctrl #(
  parameter logic [4:0] MUL_OPC    = 5'h03,
  parameter logic [4:0] HLT_OPC    = 5'h1F,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_opcode,
  input  logic [2:0] id_rs1,
  input  logic [2:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_opcode,
  input  logic [2:0] ex_rd,
  input  logic       ex_wr_rd,
  input  logic [4:0] wb_opcode,
  input  logic       branch_taken,
  input  logic       resume,
  output logic       pc_en,
  output logic       pc_sel,
  output logic       if_id_en,
  output logic       if_id_flush,
  output logic       id_ex_en,
  output logic       id_ex_flush,
  output logic       ex_wb_en,
  output logic       halted
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MULW = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [3:0] MCNT_LOAD = 4'(MUL_CYCLES - 2);

  state_t     state, state_nx;
  logic [3:0] mcnt, mcnt_nx;
  logic       halt_mask, halt_mask_nx;
  logic       raw_hz;

  // The ID opcode carries no control decision here; the hazard check uses register fields only.
  logic unused_inputs;
  assign unused_inputs = ^id_opcode;

  assign raw_hz = ex_wr_rd & ((id_use_rs1 & (id_rs1 == ex_rd)) |
                              (id_use_rs2 & (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      mcnt      <= 4'd0;
      halt_mask <= 1'b0;
    end else begin
      state     <= state_nx;
      mcnt      <= mcnt_nx;
      halt_mask <= halt_mask_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    mcnt_nx      = mcnt;
    halt_mask_nx = halt_mask;
    pc_en        = 1'b0;
    pc_sel       = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_wb_en     = 1'b0;
    halted       = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          halt_mask_nx = 1'b0;
          // The HLT that caused the last park is still in EX/WB right after resume.
          if ((wb_opcode == HLT_OPC) && !halt_mask) begin
            state_nx = HALT;
          end else if (ex_opcode == MUL_OPC) begin
            mcnt_nx  = MCNT_LOAD;
            state_nx = MULW;
          end else if (branch_taken) begin
            pc_en       = 1'b1;
            pc_sel      = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_wb_en    = 1'b1;
          end else if (raw_hz) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_wb_en    = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            id_ex_en = 1'b1;
            ex_wb_en = 1'b1;
          end
        end
        MULW: begin
          if (mcnt != 4'd0) begin
            mcnt_nx = mcnt - 4'd1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            id_ex_en = 1'b1;
            ex_wb_en = 1'b1;
            state_nx = RUN;
          end
        end
        HALT: begin
          halted = 1'b1;
          if (resume) begin
            state_nx     = RUN;
            halt_mask_nx = 1'b1;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

`ifdef PIPELINE_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= 16'd0;
    end else if (!pc_en && (state != HALT) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, directed corner sequences, randomized run vs reference model.
module tb_pipeline_ctrl;

  localparam logic [4:0] MUL = 5'h03;
  localparam logic [4:0] HLT = 5'h1F;
  localparam int MUL_CYCLES  = 4;

  // {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_wb_en, halted}
  localparam logic [7:0] ZERO = 8'b0000_0000;
  localparam logic [7:0] NORM = 8'b1010_1010;
  localparam logic [7:0] BR   = 8'b1111_1110;
  localparam logic [7:0] HAZ  = 8'b0000_1110;
  localparam logic [7:0] HLTD = 8'b0000_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_opcode = '0, ex_opcode = '0, wb_opcode = '0;
  logic [2:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_wr_rd = 0, branch_taken = 0, resume = 0;
  logic pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_wb_en, halted;
  logic [7:0] outs;
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  assign outs = {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_wb_en, halted};

  pipeline_ctrl #(.MUL_OPC(MUL), .HLT_OPC(HLT), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .ex_wr_rd(ex_wr_rd), .wb_opcode(wb_opcode), .branch_taken(branch_taken), .resume(resume),
    .pc_en(pc_en), .pc_sel(pc_sel), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_wb_en(ex_wb_en), .halted(halted)
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: remaining MUL cycles, parked flag, post-resume mask, stall tally.
  int m_mul_left;
  bit m_parked;
  bit m_mask;
  int m_stall;

  task automatic m_reset();
    m_mul_left = 0;
    m_parked   = 0;
    m_mask     = 0;
    m_stall    = 0;
  endtask

  function automatic logic [7:0] model_out();
    bit haz;
    if (!rst) return ZERO;
    if (m_parked) return HLTD;
    if (m_mul_left > 0) return (m_mul_left == 1) ? NORM : ZERO;
    if (wb_opcode == HLT && !m_mask) return ZERO;
    if (ex_opcode == MUL) return ZERO;
    if (branch_taken) return BR;
    haz = ex_wr_rd && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    return haz ? HAZ : NORM;
  endfunction

  task automatic model_update();
    logic [7:0] o;
    o = model_out();
    if (!rst) begin
      m_reset();
    end else begin
      if (!m_parked && !o[7] && m_stall < 16'hFFFF) m_stall++;
      if (m_parked) begin
        if (resume) begin
          m_parked = 0;
          m_mask   = 1;
        end
      end else if (m_mul_left > 0) begin
        m_mul_left--;
      end else begin
        if (wb_opcode == HLT && !m_mask) m_parked = 1;
        else if (ex_opcode == MUL) m_mul_left = MUL_CYCLES - 1;
        m_mask = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input logic [7:0] exp_c, input bit use_model, input string name);
    logic [7:0] e;
    @(negedge clk);
    e = use_model ? model_out() : exp_c;
    chk(name, {8'h00, outs}, {8'h00, e});
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    if (use_model) chk({name, "_stall"}, stall_cnt, 16'(m_stall));
`endif
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clear_in();
    id_opcode = '0; ex_opcode = '0; wb_opcode = '0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_wr_rd = 0; branch_taken = 0; resume = 0;
  endtask

  task automatic reset_seq(input int n);
    rst = 0;
    m_reset();
    repeat (n) step(ZERO, 0, "reset_outputs");
    rst = 1;
  endtask

  typedef struct {
    logic [2:0] rs1, rs2, rd;
    logic       u1, u2, wr, br, res;
    logic [4:0] idop;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 5'd0, NORM, "idle_run"};
    tbl[1] = '{3'd0, 3'd3, 3'd3, 0, 1, 1, 0, 0, 5'd0, HAZ,  "raw_rs2"};
    tbl[2] = '{3'd0, 3'd3, 3'd3, 0, 1, 0, 0, 0, 5'd0, NORM, "no_wr_no_stall"};
    tbl[3] = '{3'd5, 3'd0, 3'd5, 1, 0, 1, 0, 0, 5'd0, HAZ,  "raw_rs1"};
    tbl[4] = '{3'd5, 3'd0, 3'd5, 0, 0, 1, 0, 0, 5'd0, NORM, "rs1_unused"};
    tbl[5] = '{3'd0, 3'd2, 3'd3, 0, 1, 1, 0, 0, 5'd0, NORM, "rs2_mismatch"};
    tbl[6] = '{3'd0, 3'd3, 3'd3, 0, 1, 1, 1, 0, 5'd0, BR,   "branch_over_hazard"};
    tbl[7] = '{3'd0, 3'd0, 3'd0, 0, 0, 0, 1, 0, 5'd0, BR,   "branch_only"};
    tbl[8] = '{3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 1, 5'd0, NORM, "resume_in_run"};
    tbl[9] = '{3'd1, 3'd1, 3'd6, 1, 1, 1, 0, 0, HLT,  NORM, "hlt_in_id_only"};

    clear_in();
    m_reset();
    #2;

    // Reset held with a MUL in EX, then normal flow on release.
    ex_opcode = MUL;
    reset_seq(3);
    ex_opcode = '0;
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    chk("stall_after_reset", stall_cnt, 16'd0);
`endif
    step(NORM, 0, "first_run_after_reset");

    // Multi-cycle MUL freeze.
    ex_opcode = MUL;
    step(ZERO, 0, "mul_c1");
    step(ZERO, 0, "mul_c2");
    step(ZERO, 0, "mul_c3");
    step(NORM, 0, "mul_exit");
    ex_opcode = '0;
    step(NORM, 0, "mul_back_run");
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    chk("stall_after_mul", stall_cnt, 16'd3);
`endif

    foreach (tbl[i]) begin
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; ex_rd = tbl[i].rd;
      id_use_rs1 = tbl[i].u1; id_use_rs2 = tbl[i].u2; ex_wr_rd = tbl[i].wr;
      branch_taken = tbl[i].br; resume = tbl[i].res; id_opcode = tbl[i].idop;
      step(tbl[i].exp, 0, tbl[i].name);
    end
    clear_in();

    // Halt, park, resume with HLT still in WB.
    wb_opcode = HLT;
    step(ZERO, 0, "halt_detect");
    for (int i = 0; i < 10; i++) step(HLTD, 0, "halt_parked");
    resume = 1;
    step(HLTD, 0, "halt_resume_cycle");
    resume = 0;
    step(NORM, 0, "halt_masked_first_run");
    step(ZERO, 0, "halt_redetect");
    step(HLTD, 0, "halt_parked_again");
    resume = 1;
    step(HLTD, 0, "halt_resume_again");
    resume = 0;
    wb_opcode = '0;
    step(NORM, 0, "halt_exit_run");

    // Reset during MULW.
    ex_opcode = MUL;
    step(ZERO, 0, "mulr_c1");
    step(ZERO, 0, "mulr_c2");
    rst = 0;
    m_reset();
    #1;
    chk("reset_async_mid_mul", {8'h00, outs}, 16'h0000);
    step(ZERO, 0, "reset_hold_mid_mul");
    rst = 1;
    ex_opcode = '0;
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    chk("stall_after_mid_reset", stall_cnt, 16'd0);
`endif
    step(NORM, 0, "run_after_mid_reset");

    // Randomized run against the reference model.
    reset_seq(2);
    for (int i = 0; i < 600; i++) begin
      id_opcode    = 5'($urandom_range(0, 31));
      id_rs1       = 3'($urandom_range(0, 3));
      id_rs2       = 3'($urandom_range(0, 3));
      ex_rd        = 3'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      ex_wr_rd     = 1'($urandom_range(0, 1));
      ex_opcode    = ($urandom_range(0, 9) == 0) ? MUL : 5'($urandom_range(0, 31));
      wb_opcode    = ($urandom_range(0, 14) == 0) ? HLT : 5'($urandom_range(0, 31));
      branch_taken = ($urandom_range(0, 3) == 0);
      resume       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 0;
        m_reset();
      end else begin
        rst = 1;
      end
      step(ZERO, 1, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the 4-stage pipeline (IF, ID, EX, WB).
- Drives per-latch enable and flush controls for the IF/ID, ID/EX and EX/WB latches and the PC.
- Inserts stalls on RAW hazards against the EX stage, freezes the pipe during multi-cycle MUL execution, and flushes on a taken branch.
- Parks the core on HLT.

Parameters:
- MUL_OPC, 5'h03, opcode of the multi-cycle multiply.
- HLT_OPC, 5'h1F, opcode of the halt instruction.
- MUL_CYCLES, 4, total EX-stage cycles for MUL (legal range 2..15).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_opcode  in  5  opcode in ID stage.
- id_rs1  in  3  source register 1 of ID instruction.
- id_rs2  in  3  source register 2 of ID instruction.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_opcode  in  5  opcode in EX stage (ID/EX latch output).
- ex_rd  in  3  destination register in EX stage.
- ex_wr_rd  in  1  EX instruction writes ex_rd.
- wb_opcode  in  5  opcode in WB stage (EX/WB latch output).
- branch_taken  in  1  EX resolved a taken branch this cycle.
- resume  in  1  single-cycle pulse that leaves HALT.
- pc_en  out  1  PC register update enable.
- pc_sel  out  1  1 = load branch target, 0 = PC+1.
- if_id_en  out  1  IF/ID latch capture enable.
- if_id_flush  out  1  IF/ID loads NOP.
- id_ex_en  out  1  ID/EX latch capture enable.
- id_ex_flush  out  1  ID/EX loads NOP (bubble).
- ex_wb_en  out  1  EX/WB latch capture enable.
- halted  out  1  core is in HALT.

Behaviour:
- State register: RUN (2'd0), MULW (2'd1), HALT (2'd2). 4-bit down-counter mcnt.
- Reset (rst=0, async): state=RUN, mcnt=0. While rst=0, every output is forced to 0 regardless of state.
- All outputs are combinational from the registered state/mcnt and the current inputs.
- Priority when several conditions hold in RUN: halt > mul > branch > hazard.
- RUN, halt: wb_opcode==HLT_OPC.
  - All enables and flushes = 0; next state HALT.
- RUN, mul: ex_opcode==MUL_OPC.
  - pc_en = if_id_en = id_ex_en = ex_wb_en = 0.
  - mcnt <= MUL_CYCLES-2; next state MULW.
- RUN, branch: branch_taken=1.
  - pc_en=1, pc_sel=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_flush=1, ex_wb_en=1.
  - A hazard in the same cycle is ignored, because the dependent instruction is flushed.
- RUN, hazard: ex_wr_rd & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - pc_en=0, if_id_en=0; id_ex_en=1 with id_ex_flush=1 (one bubble); ex_wb_en=1.
  - Lasts exactly 1 cycle per hazard.
  - No WB-stage hazard check: the register file writes before it reads.
- RUN, otherwise: pc_en = if_id_en = id_ex_en = ex_wb_en = 1; flushes 0; pc_sel 0.
- MULW:
  - While mcnt != 0: all enables 0, mcnt decrements.
  - When mcnt == 0: pc_en = if_id_en = id_ex_en = ex_wb_en = 1; next state RUN.
  - A hazard or branch is not evaluated on the MULW exit cycle.
  - Total MUL occupancy in EX = MUL_CYCLES cycles.
- HALT:
  - halted=1; all enables 0.
  - resume=1 → next state RUN. The HLT instruction is then still in EX/WB, so on exit the RUN halt check is masked for one cycle: a 1-bit flag is set on HALT exit and cleared after one RUN cycle.
  - resume outside HALT is ignored.
- Reset asserted mid-MULW or mid-HALT: immediately returns to RUN with mcnt=0; outputs 0 until rst deasserts.

Optional Feature:
- Macro: PIPELINE_CTRL_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt[15:0]: cycles in which pc_en=0 while rst=1 and state!=HALT.
  - Saturates at 16'hFFFF; async reset to 0; not cleared by resume.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles with ex_opcode=MUL_OPC → all outputs 0; first cycle after release in RUN with no hazard → pc_en = if_id_en = id_ex_en = ex_wb_en = 1.
- RAW hazard: ex_wr_rd=1, ex_rd=3, id_use_rs2=1, id_rs2=3 for 1 cycle → pc_en=0, if_id_en=0, id_ex_flush=1 for exactly that cycle; with ex_wr_rd=0 → no stall.
- MUL: ex_opcode=5'h03 held in RUN, MUL_CYCLES=4 → ex_wb_en=0 for 3 consecutive cycles, then 1 on the 4th; back to RUN.
- Branch plus hazard in the same cycle → pc_sel=1, if_id_flush=1, id_ex_flush=1, pc_en=1; no stall cycle.
- Halt: wb_opcode=5'h1F → halted=1 next cycle, all enables 0 for 10 cycles; resume pulse → RUN; held wb_opcode=5'h1F does not re-halt on the first RUN cycle.
- Reset mid-MUL (after 1 MULW cycle), then release → RUN with mcnt=0. With PIPELINE_CTRL_STALL_CNT_EN defined, stall_cnt=0 after reset, and stall_cnt=3 after one full MUL with MUL_CYCLES=4.
